multicycle_ctrl: RTL and testbench
==================================

Name:
multicycle_ctrl

Overview:
Main multicycle control unit for the ARM-subset core. A Moore state machine sequences fetch, decode, execute, memory and writeback over 3-5 cycles per instruction. It owns the NZCV flags register. Every architectural write (PC, register file, memory, flags) is gated by conditional-execution evaluation against the stored flags.

Parameters:
- PC_REG, default 4'd15: register index that redirects a writeback to the PC.
- FLAGS_RST, default 4'b0000: reset value of the NZCV register.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- cond  in  4  instr[31:28], condition field.
- op  in  2  instr[27:26]; 00 data-processing, 01 memory, 10 branch, 11 illegal.
- funct  in  6  instr[25:20]; [5]=I (immediate), [4:1]=cmd or {P,U,B,W}, [0]=S or L.
- rd  in  4  instr[15:12], destination register.
- alu_flags  in  4  NZCV from the ALU in the current cycle.
- pc_write  out  1  PC load enable.
- adr_src  out  1  memory address select; 0=PC, 1=ALUOut.
- mem_write  out  1  data memory write enable.
- ir_write  out  1  instruction register load enable.
- reg_write  out  1  register file write enable.
- result_src  out  2  00=ALUOut, 01=read data, 10=ALU direct.
- alu_src_a  out  1  0=Rn, 1=PC.
- alu_src_b  out  2  00=Rm, 01=extended immediate, 10=constant 4.
- alu_control  out  2  00=ADD, 01=SUB, 10=AND, 11=ORR.
- imm_src  out  2  equal to op; the extender decodes it.
- reg_src  out  2  [0] selects R15 as Rn for branches; [1] selects Rd as the second read address for stores.
- flags  out  4  current stored NZCV, for debug visibility.

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, encoded in a 4-bit enum.
- While reset is high: state=FETCH, flags=FLAGS_RST, and every output forced to 0. The first active cycle after reset release is FETCH.
- FETCH: ir_write=1, pc_write=1, adr_src=0, alu_src_a=1, alu_src_b=10, ADD, result_src=10. Next state is DECODE.
- DECODE: alu_src_a=1, alu_src_b=10, ADD, result_src=10 (PC+8 path).
  - op=01 -> MEMADR.
  - op=10 -> BRANCH.
  - op=00 with I=0 -> EXECR; with I=1 -> EXECI.
  - op=11 -> FETCH, with no writes.
- MEMADR: alu_src_b=01, ADD. L=1 -> MEMRD; L=0 -> MEMWR.
- MEMRD: adr_src=1, then MEMWB.
- MEMWB: result_src=01, reg_write=cond_ex, then FETCH. If rd==PC_REG, pc_write=cond_ex as well.
- MEMWR: adr_src=1, mem_write=cond_ex, then FETCH.
- EXECR uses alu_src_b=00; EXECI uses alu_src_b=01. alu_control decodes from cmd:
  - 0100 -> ADD; 0010 and 1010(CMP) -> SUB; 0000 -> AND; 1100 -> ORR.
  - Any other cmd -> ADD, with writeback suppressed.
- EXECR/EXECI transitions: CMP -> FETCH with no writeback; otherwise -> ALUWB.
- Flag update in EXECR/EXECI, at the rising edge ending the state:
  - if S=1 (always for CMP) and cond_ex: NZ <- alu_flags[3:2].
  - CV <- alu_flags[1:0] only for ADD/SUB/CMP; AND/ORR preserve CV.
- ALUWB: result_src=00, reg_write=cond_ex, pc_write=cond_ex when rd==PC_REG. Then FETCH.
- BRANCH: alu_src_a=0 with reg_src[0]=1, alu_src_b=01, ADD, result_src=10, pc_write=cond_ex. Then FETCH.
- cond_ex is combinational from cond and the stored flags, never from the live alu_flags. Codes: EQ/NE/CS/CC/MI/PL/VS/VC/HI/LS/GE/LT/GT/LE per ARM; AL=1110 is always true; 1111 is false.
- Simultaneous flag write and cond evaluation in the same state: cond_ex uses the pre-update flags; the update lands at the clock edge.
- Reset mid-instruction: aborts immediately. No partial write persists beyond the asynchronous clear; outputs drop to 0 in the same cycle.
- Latency in cycles:
  - branch 3.
  - DP 4 (CMP 3).
  - STR 4.
  - LDR 5.

Decomposition:
- Package ctrl_pkg:
  - state_t enum.
  - op encodings.
  - cmd constants.
  - alu_control encodings.
  - src-select encodings.
  - condition-code constants.
- Sub-module: the existing cond_check, instantiated with flags = stored NZCV, producing cond_ex.
- Flags register and FSM stay in multicycle_ctrl.

Test Plan:
- Reset asserted mid-MEMRD -> same cycle all outputs 0, flags=0000; after release FETCH with ir_write=1 and pc_write=1.
- ADD R1,R2,R3 with cond=1110, S=0 -> states FETCH, DECODE, EXECR, ALUWB; reg_write=1 only in ALUWB; flags unchanged.
- CMP with alu_flags=0110 (Z=1, C=1), then BEQ -> flags=0110 after EXECR; BRANCH asserts pc_write=1. Repeat as BNE -> pc_write=0.
- LDR R15 with cond=AL -> five cycles; MEMWB asserts reg_write=1 and pc_write=1; result_src=01.
- STR with cond=0000 (EQ) and Z=0 -> MEMWR mem_write=0; returns to FETCH in the next cycle.
- ANDS with alu_flags=1011 from stored 0011 -> flags=1011 (NZ updated, CV preserved). op=11 -> DECODE goes directly to FETCH with no writes.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, instruction
// fields, datapath select codes and condition codes.
package ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXECR  = 4'd6,
      S_EXECI  = 4'd7,
      S_ALUWB  = 4'd8,
      S_BRANCH = 4'd9
   } state_t;

   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;
   localparam logic [1:0] OP_ILL = 2'b11;

   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_CMP = 4'b1010;
   localparam logic [3:0] CMD_ORR = 4'b1100;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_ORR = 2'b11;

   localparam logic       ADR_PC     = 1'b0;
   localparam logic       ADR_ALUOUT = 1'b1;
   localparam logic       SRCA_RN    = 1'b0;
   localparam logic       SRCA_PC    = 1'b1;
   localparam logic [1:0] SRCB_RM    = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_FOUR  = 2'b10;
   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_RDATA  = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;

   typedef struct packed {
      logic [1:0] alu;
      logic       valid;
      logic       is_cmp;
      logic       cv_upd;
   } cmd_dec_t;

   // Unrecognised commands still drive ADD but are flagged so no state changes.
   function automatic cmd_dec_t decode_cmd(input logic [3:0] cmd);
      cmd_dec_t d;
      d = '{alu: ALU_ADD, valid: 1'b1, is_cmp: 1'b0, cv_upd: 1'b1};
      case (cmd)
         CMD_ADD: d.alu = ALU_ADD;
         CMD_SUB: d.alu = ALU_SUB;
         CMD_CMP: begin d.alu = ALU_SUB; d.is_cmp = 1'b1; end
         CMD_AND: begin d.alu = ALU_AND; d.cv_upd = 1'b0; end
         CMD_ORR: begin d.alu = ALU_ORR; d.cv_upd = 1'b0; end
         default: d.valid = 1'b0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/cond_check.sv
// ARM condition-field evaluation against an NZCV flag vector.
module cond_check
   import ctrl_pkg::*;
(
   input  logic [3:0] i_cond,
   input  logic [3:0] i_flags,
   output logic       o_cond_ex
);

   logic w_n, w_z, w_c, w_v;
   assign {w_n, w_z, w_c, w_v} = i_flags;

   // NOTE: the default assignment before the case keeps this purely combinational (no latch).
   always_comb begin
      o_cond_ex = 1'b0;
      case (i_cond)
         COND_EQ: o_cond_ex = w_z;
         COND_NE: o_cond_ex = ~w_z;
         COND_CS: o_cond_ex = w_c;
         COND_CC: o_cond_ex = ~w_c;
         COND_MI: o_cond_ex = w_n;
         COND_PL: o_cond_ex = ~w_n;
         COND_VS: o_cond_ex = w_v;
         COND_VC: o_cond_ex = ~w_v;
         COND_HI: o_cond_ex = w_c & ~w_z;
         COND_LS: o_cond_ex = ~w_c | w_z;
         COND_GE: o_cond_ex = (w_n == w_v);
         COND_LT: o_cond_ex = (w_n != w_v);
         COND_GT: o_cond_ex = ~w_z & (w_n == w_v);
         COND_LE: o_cond_ex = w_z | (w_n != w_v);
         COND_AL: o_cond_ex = 1'b1;
         default: o_cond_ex = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle Moore controller for the ARM-subset core; owns the NZCV register
// and gates every architectural write with the condition check.
module multicycle_ctrl
   import ctrl_pkg::*;
#(
   parameter logic [3:0] PC_REG    = 4'd15,
   parameter logic [3:0] FLAGS_RST = 4'b0000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] cond,
   input  logic [1:0] op,
   input  logic [5:0] funct,
   input  logic [3:0] rd,
   input  logic [3:0] alu_flags,
   output logic       pc_write,
   output logic       adr_src,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_write,
   output logic [1:0] result_src,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_control,
   output logic [1:0] imm_src,
   output logic [1:0] reg_src,
   output logic [3:0] flags
);

   state_t     r_state;
   state_t     w_next;
   logic [3:0] r_flags;
   logic       w_cond_ex;
   cmd_dec_t   w_dec;
   logic       w_rd_pc;
   logic       w_in_exec;
   logic       w_flags_we;

   // Condition is judged on the stored flags, so an update in EXEC lands after evaluation.
   cond_check u_cond_check (
      .i_cond    (cond),
      .i_flags   (r_flags),
      .o_cond_ex (w_cond_ex)
   );

   assign w_dec      = decode_cmd(funct[4:1]);
   assign w_rd_pc    = (rd == PC_REG);
   assign w_in_exec  = (r_state == S_EXECR) || (r_state == S_EXECI);
   assign w_flags_we = w_in_exec & w_dec.valid & (funct[0] | w_dec.is_cmp) & w_cond_ex;
   assign flags      = r_flags;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_FETCH;
         r_flags <= FLAGS_RST;
      end else begin
         r_state <= w_next;
         if (w_flags_we) begin
            r_flags[3:2] <= alu_flags[3:2];
            if (w_dec.cv_upd) r_flags[1:0] <= alu_flags[1:0];
         end
      end
   end

   always_comb begin
      w_next = S_FETCH;
      case (r_state)
         S_FETCH:  w_next = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_MEM:  w_next = S_MEMADR;
               OP_BR:   w_next = S_BRANCH;
               OP_DP:   w_next = funct[5] ? S_EXECI : S_EXECR;
               OP_ILL:  w_next = S_FETCH;
               default: w_next = S_FETCH;
            endcase
         end
         S_MEMADR: w_next = funct[0] ? S_MEMRD : S_MEMWR;
         S_MEMRD:  w_next = S_MEMWB;
         S_EXECR,
         S_EXECI:  w_next = w_dec.is_cmp ? S_FETCH : S_ALUWB;
         default:  w_next = S_FETCH;
      endcase
   end

   // Reset gates the outputs combinationally so an abort clears them within the cycle.
   always_comb begin
      pc_write    = 1'b0;
      adr_src     = ADR_PC;
      mem_write   = 1'b0;
      ir_write    = 1'b0;
      reg_write   = 1'b0;
      result_src  = RES_ALUOUT;
      alu_src_a   = SRCA_RN;
      alu_src_b   = SRCB_RM;
      alu_control = ALU_ADD;
      imm_src     = 2'b00;
      reg_src     = 2'b00;
      if (!reset) begin
         imm_src = op;
         case (r_state)
            S_FETCH: begin
               ir_write   = 1'b1;
               pc_write   = 1'b1;
               alu_src_a  = SRCA_PC;
               alu_src_b  = SRCB_FOUR;
               result_src = RES_ALU;
            end
            S_DECODE: begin
               alu_src_a  = SRCA_PC;
               alu_src_b  = SRCB_FOUR;
               result_src = RES_ALU;
               reg_src[0] = (op == OP_BR);
               reg_src[1] = (op == OP_MEM) & ~funct[0];
            end
            S_MEMADR: begin
               alu_src_b  = SRCB_IMM;
               reg_src[1] = ~funct[0];
            end
            S_MEMRD:  adr_src = ADR_ALUOUT;
            S_MEMWB: begin
               result_src = RES_RDATA;
               reg_write  = w_cond_ex;
               pc_write   = w_cond_ex & w_rd_pc;
            end
            S_MEMWR: begin
               adr_src    = ADR_ALUOUT;
               mem_write  = w_cond_ex;
               reg_src[1] = 1'b1;
            end
            S_EXECR:  alu_control = w_dec.alu;
            S_EXECI: begin
               alu_src_b   = SRCB_IMM;
               alu_control = w_dec.alu;
            end
            S_ALUWB: begin
               reg_write = w_cond_ex & w_dec.valid;
               pc_write  = w_cond_ex & w_dec.valid & w_rd_pc;
            end
            S_BRANCH: begin
               reg_src[0] = 1'b1;
               alu_src_b  = SRCB_IMM;
               result_src = RES_ALU;
               pc_write   = w_cond_ex;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: the driver queues per-cycle expected
// control words, the monitor pops and compares one on every falling edge.
module tb_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] cond, rd, alu_flags;
   logic [1:0] op;
   logic [5:0] funct;
   logic       pc_write, adr_src, mem_write, ir_write, reg_write, alu_src_a;
   logic [1:0] result_src, alu_src_b, alu_control, imm_src, reg_src;
   logic [3:0] flags;

   multicycle_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .cond        (cond),
      .op          (op),
      .funct       (funct),
      .rd          (rd),
      .alu_flags   (alu_flags),
      .pc_write    (pc_write),
      .adr_src     (adr_src),
      .mem_write   (mem_write),
      .ir_write    (ir_write),
      .reg_write   (reg_write),
      .result_src  (result_src),
      .alu_src_a   (alu_src_a),
      .alu_src_b   (alu_src_b),
      .alu_control (alu_control),
      .imm_src     (imm_src),
      .reg_src     (reg_src),
      .flags       (flags)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [19:0] word;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [19:0] obs;

   // Word layout: pcw adr memw irw regw res[2] srca srcb[2] alu[2] imm[2] rsrc[2] flags[4]
   assign obs = {pc_write, adr_src, mem_write, ir_write, reg_write, result_src, alu_src_a,
                 alu_src_b, alu_control, imm_src, reg_src, flags};

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         n_tests++;
         if (obs !== mon_e.word) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (pcw adr memw irw regw res srca srcb alu imm rsrc nzcv)",
                     mon_e.name, obs, mon_e.word);
         end
      end
   end

   task automatic expect_cyc(input string name, input logic pcw, adr, memw, irw, regw,
                             input logic [1:0] res, input logic srca, input logic [1:0] srcb,
                             input logic [1:0] alu, imm, rsrc, input logic [3:0] flg);
      exp_t e;
      e.name = name;
      e.word = {pcw, adr, memw, irw, regw, res, srca, srcb, alu, imm, rsrc, flg};
      exp_q.push_back(e);
   endtask

   task automatic issue(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                        input logic [3:0] d, input logic [3:0] af);
      cond = c; op = o; funct = f; rd = d; alu_flags = af;
   endtask

   task automatic run(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1;
      issue(4'b1110, 2'b00, 6'b001000, 4'd1, 4'b1111);
      expect_cyc("reset_idle", 0,0,0,0,0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000);
      run(2);
      reset = 1'b0;

      // ADD R1,R2,R3 (S=0): live alu_flags must be ignored
      expect_cyc("add_fetch",  1,0,0,1,0, 2'b10, 1, 2'b10, 2'b00, 2'b00, 2'b00, 4'b0000);
      expect_cyc("add_decode", 0,0,0,0,0, 2'b10, 1, 2'b10, 2'b00, 2'b00, 2'b00, 4'b0000);
      expect_cyc("add_execr",  0,0,0,0,0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000);
      expect_cyc("add_aluwb",  0,0,0,0,1, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000);
      run(4);

      // CMP producing Z=1,C=1
      issue(4'b1110, 2'b00, 6'b010101, 4'd0, 4'b0110);
      expect_cyc("cmp1_fetch",  1,0,0,1,0, 2'b10, 1, 2'b10, 2'b00, 2'b00, 2'b00, 4'b0000);
      expect_cyc("cmp1_decode", 0,0,0,0,0, 2'b10, 1, 2'b10, 2'b00, 2'b00, 2'b00, 4'b0000);
      expect_cyc("cmp1_execr",  0,0,0,0,0, 2'b00, 0, 2'b00, 2'b01, 2'b00, 2'b00, 4'b0000);
      run(3);

      // BEQ taken
      issue(4'b0000, 2'b10, 6'b100000, 4'd0, 4'b0000);
      expect_cyc("beq_fetch",  1,0,0,1,0, 2'b10, 1, 2'b10, 2'b00, 2'b10, 2'b00, 4'b0110);
      expect_cyc("beq_decode", 0,0,0,0,0, 2'b10, 1, 2'b10, 2'b00, 2'b10, 2'b01, 4'b0110);
      expect_cyc("beq_branch", 1,0,0,0,0, 2'b10, 0, 2'b01, 2'b00, 2'b10, 2'b01, 4'b0110);
      run(3);

      // BNE not taken
      issue(4'b0001, 2'b10, 6'b100000, 4'd0, 4'b0000);
      expect_cyc("bne_fetch",  1,0,0,1,0, 2'b10, 1, 2'b10, 2'b00, 2'b10, 2'b00, 4'b0110);
      expect_cyc("bne_decode", 0,0,0,0,0, 2'b10, 1, 2'b10, 2'b00, 2'b10, 2'b01, 4'b0110);
      expect_cyc("bne_branch", 0,0,0,0,0, 2'b10, 0, 2'b01, 2'b00, 2'b10, 2'b01, 4'b0110);
      run(3);

      // LDR R15 (AL): five cycles, MEMWB writes register and PC
      issue(4'b1110, 2'b01, 6'b011001, 4'd15, 4'b0000);
      expect_cyc("ldr_fetch",  1,0,0,1,0, 2'b10, 1, 2'b10, 2'b00, 2'b01, 2'b00, 4'b0110);
      expect_cyc("ldr_decode", 0,0,0,0,0, 2'b10, 1, 2'b10, 2'b00, 2'b01, 2'b00, 4'b0110);
      expect_cyc("ldr_memadr", 0,0,0,0,0, 2'b00, 0, 2'b01, 2'b00, 2'b01, 2'b00, 4'b0110);
      expect_cyc("ldr_memrd",  0,1,0,0,0, 2'b00, 0, 2'b00, 2'b00, 2'b01, 2'b00, 4'b0110);
      expect_cyc("ldr_memwb",  1,0,0,0,1, 2'b01, 0, 2'b00, 2'b00, 2'b01, 2'b00, 4'b0110);
      run(5);

      // CMP loading 0011, then ANDS (immediate) with NZ=10 must keep CV=11
      issue(4'b1110, 2'b00, 6'b010101, 4'd0, 4'b0011);
      expect_cyc("cmp2_fetch",  1,0,0,1,0, 2'b10, 1, 2'b10, 2'b00, 2'b00, 2'b00, 4'b0110);
      expect_cyc("cmp2_decode", 0,0,0,0,0, 2'b10, 1, 2'b10, 2'b00, 2'b00, 2'b00, 4'b0110);
      expect_cyc("cmp2_execr",  0,0,0,0,0, 2'b00, 0, 2'b00, 2'b01, 2'b00, 2'b00, 4'b0110);
      run(3);
      issue(4'b1110, 2'b00, 6'b100001, 4'd2, 4'b1000);
      expect_cyc("ands_fetch",  1,0,0,1,0, 2'b10, 1, 2'b10, 2'b00, 2'b00, 2'b00, 4'b0011);
      expect_cyc("ands_decode", 0,0,0,0,0, 2'b10, 1, 2'b10, 2'b00, 2'b00, 2'b00, 4'b0011);
      expect_cyc("ands_execi",  0,0,0,0,0, 2'b00, 0, 2'b01, 2'b10, 2'b00, 2'b00, 4'b0011);
      expect_cyc("ands_aluwb",  0,0,0,0,1, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b1011);
      run(4);

      // STREQ with Z=0: no memory write
      issue(4'b0000, 2'b01, 6'b011000, 4'd3, 4'b0000);
      expect_cyc("streq_fetch",  1,0,0,1,0, 2'b10, 1, 2'b10, 2'b00, 2'b01, 2'b00, 4'b1011);
      expect_cyc("streq_decode", 0,0,0,0,0, 2'b10, 1, 2'b10, 2'b00, 2'b01, 2'b10, 4'b1011);
      expect_cyc("streq_memadr", 0,0,0,0,0, 2'b00, 0, 2'b01, 2'b00, 2'b01, 2'b10, 4'b1011);
      expect_cyc("streq_memwr",  0,1,0,0,0, 2'b00, 0, 2'b00, 2'b00, 2'b01, 2'b10, 4'b1011);
      run(4);

      // STR AL: memory write enabled
      issue(4'b1110, 2'b01, 6'b011000, 4'd3, 4'b0000);
      expect_cyc("stral_fetch",  1,0,0,1,0, 2'b10, 1, 2'b10, 2'b00, 2'b01, 2'b00, 4'b1011);
      expect_cyc("stral_decode", 0,0,0,0,0, 2'b10, 1, 2'b10, 2'b00, 2'b01, 2'b10, 4'b1011);
      expect_cyc("stral_memadr", 0,0,0,0,0, 2'b00, 0, 2'b01, 2'b00, 2'b01, 2'b10, 4'b1011);
      expect_cyc("stral_memwr",  0,1,1,0,0, 2'b00, 0, 2'b00, 2'b00, 2'b01, 2'b10, 4'b1011);
      run(4);

      // ORR immediate with cond=1111 (never): no register write
      issue(4'b1111, 2'b00, 6'b111000, 4'd4, 4'b0000);
      expect_cyc("orrnv_fetch",  1,0,0,1,0, 2'b10, 1, 2'b10, 2'b00, 2'b00, 2'b00, 4'b1011);
      expect_cyc("orrnv_decode", 0,0,0,0,0, 2'b10, 1, 2'b10, 2'b00, 2'b00, 2'b00, 4'b1011);
      expect_cyc("orrnv_execi",  0,0,0,0,0, 2'b00, 0, 2'b01, 2'b11, 2'b00, 2'b00, 4'b1011);
      expect_cyc("orrnv_aluwb",  0,0,0,0,0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b1011);
      run(4);

      // Illegal op: DECODE returns straight to FETCH
      issue(4'b1110, 2'b11, 6'b000000, 4'd0, 4'b0000);
      expect_cyc("ill_fetch",  1,0,0,1,0, 2'b10, 1, 2'b10, 2'b00, 2'b11, 2'b00, 4'b1011);
      expect_cyc("ill_decode", 0,0,0,0,0, 2'b10, 1, 2'b10, 2'b00, 2'b11, 2'b00, 4'b1011);
      run(2);

      // LDR aborted by reset while in MEMRD
      issue(4'b1110, 2'b01, 6'b011001, 4'd0, 4'b0000);
      expect_cyc("abort_fetch",  1,0,0,1,0, 2'b10, 1, 2'b10, 2'b00, 2'b01, 2'b00, 4'b1011);
      expect_cyc("abort_decode", 0,0,0,0,0, 2'b10, 1, 2'b10, 2'b00, 2'b01, 2'b00, 4'b1011);
      expect_cyc("abort_memadr", 0,0,0,0,0, 2'b00, 0, 2'b01, 2'b00, 2'b01, 2'b00, 4'b1011);
      run(3);
      reset = 1'b1;
      expect_cyc("abort_reset", 0,0,0,0,0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000);
      run(1);
      issue(4'b1110, 2'b11, 6'b000000, 4'd0, 4'b0000);
      reset = 1'b0;
      expect_cyc("post_fetch",  1,0,0,1,0, 2'b10, 1, 2'b10, 2'b00, 2'b11, 2'b00, 4'b0000);
      expect_cyc("post_decode", 0,0,0,0,0, 2'b10, 1, 2'b10, 2'b00, 2'b11, 2'b00, 4'b0000);
      run(2);

      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
